// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for a single-port RAM: fixed priority to port 0 with a starvation override for port 1.
// Grant one cycle after the arbitration edge; reads return RD_LAT+1 cycles after grant; requests wait (held req) until granted.
module ram_port_arbiter #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 12,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

   state_t            state_q, state_d;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              owner_q, owner_d;
   logic              m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
   logic              m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              arb;
   logic              pick1;

   always_comb begin
      state_d     = state_q;
      lat_cnt_d   = lat_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      owner_d     = owner_q;
      m0_gnt_d    = 1'b0;
      m1_gnt_d    = 1'b0;
      m0_rvalid_d = 1'b0;
      m1_rvalid_d = 1'b0;
      rdata_d     = rdata_q;
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      arb         = 1'b0;
      pick1       = 1'b0;

      case (state_q)
         IDLE: begin
            // A read grant cycle hands over to WAIT instead of arbitrating again.
            if (ram_en_q && !ram_we_q) begin
               state_d   = WAIT;
               lat_cnt_d = '0;
            end else begin
               arb = 1'b1;
            end
         end
         WAIT: begin
            if (lat_cnt_q == LAT_LAST) begin
               state_d     = IDLE;
               rdata_d     = ram_rdata;
               m0_rvalid_d = !owner_q;
               m1_rvalid_d = owner_q;
               arb         = 1'b1;
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (arb && (m0_req || m1_req)) begin
         pick1       = (m1_req && (wait_cnt_q == WAIT_MAX)) || !m0_req;
         owner_d     = pick1;
         m0_gnt_d    = !pick1;
         m1_gnt_d    = pick1;
         ram_en_d    = 1'b1;
         ram_we_d    = pick1 ? m1_we    : m0_we;
         ram_addr_d  = pick1 ? m1_addr  : m0_addr;
         ram_wdata_d = pick1 ? m1_wdata : m0_wdata;
         if (pick1) begin
            wait_cnt_d = '0;
         end else if (m1_req && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lat_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         owner_q     <= 1'b0;
         m0_gnt_q    <= 1'b0;
         m1_gnt_q    <= 1'b0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         rdata_q     <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         lat_cnt_q   <= lat_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         owner_q     <= owner_d;
         m0_gnt_q    <= m0_gnt_d;
         m1_gnt_q    <= m1_gnt_d;
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
         rdata_q     <= rdata_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   assign m0_gnt    = m0_gnt_q;
   assign m1_gnt    = m1_gnt_q;
   assign m0_rvalid = m0_rvalid_q;
   assign m1_rvalid = m1_rvalid_q;
   assign rdata     = rdata_q;
   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign busy      = (state_q == WAIT);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: instance a uses RD_LAT=1, instance b uses RD_LAT=3; both share the master inputs.
// Each instance has its own behavioural RAM that drives 16'hDEAD outside the valid read-data cycle.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [11:0] m0_addr, m1_addr;
   logic [15:0] m0_wdata, m1_wdata;

   logic        a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_ram_en, a_ram_we, a_busy;
   logic [15:0] a_rdata, a_ram_wdata, a_ram_rdata;
   logic [11:0] a_ram_addr;
   logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_ram_en, b_ram_we, b_busy;
   logic [15:0] b_rdata, b_ram_wdata, b_ram_rdata;
   logic [11:0] b_ram_addr;

   int tests = 0;
   int fails = 0;
   int excl_bad = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.DATA_W(16), .ADDR_W(12), .RD_LAT(1), .MAX_WAIT(4)) u_a (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid),
      .rdata(a_rdata), .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
      .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata), .busy(a_busy)
   );

   ram_port_arbiter #(.DATA_W(16), .ADDR_W(12), .RD_LAT(3), .MAX_WAIT(4)) u_b (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid),
      .rdata(b_rdata), .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
      .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata), .busy(b_busy)
   );

   logic [15:0] mem_a [4096];
   logic [15:0] mem_b [4096];
   logic [15:0] pa_d;
   logic        pa_v = 1'b0;
   logic [15:0] pb_d [3];
   logic [2:0]  pb_v = 3'b000;

   always @(posedge clk) begin
      if (a_ram_en && a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
      pa_v <= a_ram_en && !a_ram_we;
      pa_d <= mem_a[a_ram_addr];
      if (b_ram_en && b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
      pb_v  <= {pb_v[1:0], b_ram_en && !b_ram_we};
      pb_d[0] <= mem_b[b_ram_addr];
      pb_d[1] <= pb_d[0];
      pb_d[2] <= pb_d[1];
   end
   assign a_ram_rdata = pa_v    ? pa_d    : 16'hDEAD;
   assign b_ram_rdata = pb_v[2] ? pb_d[2] : 16'hDEAD;

   always @(negedge clk) begin
      if ((a_m0_gnt && a_m1_gnt) || (a_m0_rvalid && a_m1_rvalid) ||
          (b_m0_gnt && b_m1_gnt) || (b_m0_rvalid && b_m1_rvalid)) excl_bad++;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int lat;
      logic [15:0] got;
      logic seen;

      rst = 1'b1;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
      cyc(); cyc();
      chk("reset_a_outputs", {a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_rdata, a_ram_en,
                              a_ram_we, a_ram_addr, a_ram_wdata, a_busy}, 64'd0);
      chk("reset_a_wait_cnt", 64'(u_a.wait_cnt_q), 64'd0);
      rst = 1'b0;
      cyc();

      // single write then read on port 0
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h123; m0_wdata = 16'hBEEF;
      cyc();
      chk("wr_grant", {a_m0_gnt, a_m1_gnt, a_ram_en, a_ram_we, a_ram_addr, a_ram_wdata},
          {1'b1, 1'b0, 1'b1, 1'b1, 12'h123, 16'hBEEF});
      m0_req = 1'b0;
      cyc();
      chk("wr_after_idle", {a_m0_gnt, a_ram_en, a_ram_we, a_busy}, 64'd0);
      m0_req = 1'b1; m0_we = 1'b0;
      cyc();
      chk("rd_grant", {a_m0_gnt, a_ram_en, a_ram_we, a_ram_addr}, {1'b1, 1'b1, 1'b0, 12'h123});
      m0_req = 1'b0;
      cyc();
      chk("rd_wait", {a_busy, a_ram_en, a_m0_rvalid, a_m0_gnt}, {1'b1, 1'b0, 1'b0, 1'b0});
      cyc();
      chk("rd_rvalid", {a_m0_rvalid, a_m1_rvalid, a_busy, a_rdata}, {1'b1, 1'b0, 1'b0, 16'hBEEF});
      cyc();
      chk("rd_hold", {a_m0_rvalid, a_rdata}, {1'b0, 16'hBEEF});

      // port 1 write, then simultaneous reads
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'h456; m1_wdata = 16'h1234;
      cyc();
      chk("m1_wr_grant", {a_m0_gnt, a_m1_gnt, a_ram_we, a_ram_addr}, {1'b0, 1'b1, 1'b1, 12'h456});
      m1_req = 1'b0;
      cyc();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h123;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h456;
      cyc();
      chk("cont_m0_first", {a_m0_gnt, a_m1_gnt}, {1'b1, 1'b0});
      chk("cont_wait_cnt1", 64'(u_a.wait_cnt_q), 64'd1);
      m0_req = 1'b0;
      cyc();
      chk("cont_wait_state", {a_busy, a_m1_gnt, a_ram_en}, {1'b1, 1'b0, 1'b0});
      cyc();
      chk("cont_m1_gnt_with_rvalid", {a_m0_rvalid, a_rdata, a_m1_gnt, a_ram_en, a_ram_addr},
          {1'b1, 16'hBEEF, 1'b1, 1'b1, 12'h456});
      chk("cont_wait_cnt0", 64'(u_a.wait_cnt_q), 64'd0);
      m1_req = 1'b0;
      cyc();
      chk("cont_m1_wait", {a_busy, a_m1_rvalid}, {1'b1, 1'b0});
      cyc();
      chk("cont_m1_rvalid", {a_m1_rvalid, a_m0_rvalid, a_rdata}, {1'b1, 1'b0, 16'h1234});

      // starvation: m0 streams writes while m1 holds its request
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h010; m0_wdata = 16'hA000;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'h020; m1_wdata = 16'h5555;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk($sformatf("starve_gnt%0d", i), {a_m0_gnt, a_m1_gnt, a_ram_en},
             {(i != 4), (i == 4), 1'b1});
         if (i == 4) begin
            chk("starve_cnt_clear", 64'(u_a.wait_cnt_q), 64'd0);
            m1_req = 1'b0;
         end
      end
      chk("starve_m1_data", {a_ram_addr, a_ram_wdata}, {12'h010, 16'hA000});
      m0_req = 1'b0;
      cyc();

      // back-to-back port 1 writes
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'h000; m1_wdata = 16'hC000;
      for (int i = 0; i < 16; i++) begin
         cyc();
         chk($sformatf("b2b_%0d", i), {a_m1_gnt, a_ram_en, a_ram_we, a_busy, a_ram_addr, a_ram_wdata},
             {1'b1, 1'b1, 1'b1, 1'b0, 12'(i), 16'hC000 + 16'(i)});
         m1_addr = 12'(i + 1); m1_wdata = 16'hC000 + 16'(i + 1);
         if (i == 15) m1_req = 1'b0;
      end
      cyc();
      chk("b2b_end", {a_ram_en, a_m1_gnt}, 64'd0);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h00A;
      cyc();
      m0_req = 1'b0;
      cyc(); cyc();
      chk("b2b_readback", {a_m0_rvalid, a_rdata}, {1'b1, 16'hC00A});

      // instance b: reset in the middle of a 3-cycle read
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h300; m0_wdata = 16'h3C3C;
      cyc();
      chk("b_wr_grant", {b_m0_gnt, b_ram_en, b_ram_we}, {1'b1, 1'b1, 1'b1});
      m0_req = 1'b0;
      cyc();
      m0_req = 1'b1; m0_we = 1'b0;
      cyc();
      chk("b_rd_grant", {b_m0_gnt, b_ram_en, b_ram_we}, {1'b1, 1'b1, 1'b0});
      m0_req = 1'b0;
      cyc();
      cyc();
      chk("b_wait2_busy", {b_busy, b_m0_rvalid}, {1'b1, 1'b0});
      rst = 1'b1;
      cyc();
      chk("b_reset_outputs", {b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_rdata, b_ram_en,
                              b_ram_we, b_ram_addr, b_ram_wdata, b_busy}, 64'd0);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cyc();
         if (b_m0_rvalid || b_m1_rvalid || b_busy) seen = 1'b1;
      end
      chk("b_no_rvalid_after_reset", 64'(seen), 64'd0);

      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h300;
      cyc();
      chk("b_reread_grant", {b_m0_gnt, b_ram_en}, {1'b1, 1'b1});
      m0_req = 1'b0;
      lat = 0; got = '0;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         if (b_m0_rvalid && lat == 0) begin
            lat = k;
            got = b_rdata;
         end
      end
      chk("b_reread_latency", 64'(lat), 64'd4);
      chk("b_reread_data", 64'(got), 64'h3C3C);

      // withdrawn port 1 requests: before grant, and as a pulse inside WAIT
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h300;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h301;
      cyc();
      chk("wd_m0_grant", {b_m0_gnt, b_m1_gnt}, {1'b1, 1'b0});
      chk("wd_cnt_before", 64'(u_b.wait_cnt_q), 64'd1);
      m0_req = 1'b0; m1_req = 1'b0;
      seen = 1'b0; lat = 0;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         m1_req = (k == 1);
         if (b_m1_gnt) seen = 1'b1;
         if (b_m0_rvalid && lat == 0) lat = k;
      end
      chk("wd_no_m1_gnt", 64'(seen), 64'd0);
      chk("wd_cnt_after", 64'(u_b.wait_cnt_q), 64'd1);
      chk("wd_m0_rvalid_lat", 64'(lat), 64'd4);
      chk("gnt_rvalid_exclusive", 64'(excl_bad), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 4K x 16 program/data RAM between two masters: port 0 (CPU controller bus) and port 1 (program loader / I/O DMA).
- Fixed priority to port 0, with a starvation counter that forces a port 1 grant after MAX_WAIT lost arbitrations.
- Sits between the masters and the RAM macro, which has a fixed read latency.
- Supports one outstanding read at a time; writes complete in their grant cycle.

Parameters:
DATA_W, 16, RAM word width
ADDR_W, 12, RAM address width
RD_LAT, 1, RAM read latency in cycles (>=1): ram_rdata valid RD_LAT cycles after the enable cycle
MAX_WAIT, 4, consecutive lost cycles after which port 1 takes priority (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
m0_req  in  1  port 0 access request, held until m0_gnt
m0_we  in  1  port 0 write (1) / read (0)
m0_addr  in  ADDR_W  port 0 address
m0_wdata  in  DATA_W  port 0 write data
m0_gnt  out  1  one-cycle grant pulse to port 0
m0_rvalid  out  1  one-cycle pulse: rdata holds port 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid  same as port 0, for port 1
rdata  out  DATA_W  read data, shared; qualified by m0_rvalid/m1_rvalid
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable (only with ram_en)
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data
busy  out  1  high while in WAIT state

Behaviour:
- All outputs are registered. On reset, every output is 0, state is IDLE, and wait_cnt is 0.
- States: IDLE and WAIT.
- Arbitration edge: any rising edge in IDLE, or the edge closing the last WAIT cycle.
  - At that edge, if any req is high, pick a winner:
    - port 1 if wait_cnt==MAX_WAIT and m1_req;
    - else port 0 if m0_req;
    - else port 1.
  - The next cycle (grant cycle G) has gnt[winner]=1, ram_en=1, and ram_addr/ram_we/ram_wdata copied from the winner's inputs.
  - With no req, ram_en=0 and all gnt=0.
- Requester rules:
  - addr/we/wdata stay stable while req is high and not yet granted.
  - req may drop before grant; the request is then withdrawn and no grant is issued.
  - req still high at the edge closing G counts as a new request.
- Write grant:
  - The RAM writes at the edge closing G. No rvalid is issued.
  - State remains IDLE, so back-to-back writes sustain one per cycle.
- Read grant:
  - State goes to WAIT for cycles G+1 .. G+RD_LAT, and busy=1 in those cycles. ram_en=0 in WAIT cycles.
  - The edge closing cycle G+RD_LAT captures ram_rdata into rdata.
  - That same edge pulses rvalid for the read's owner in cycle G+RD_LAT+1 and returns to IDLE.
  - It is also an arbitration edge, so a new gnt may coincide with rvalid.
  - rdata holds its value until the next read capture.
- Starvation counter wait_cnt (0..MAX_WAIT, saturating):
  - Increments at each arbitration edge where m1_req=1 and port 0 wins.
  - Clears when port 1 is granted.
  - Holds otherwise, including during WAIT.
- Simultaneous requests with wait_cnt<MAX_WAIT: port 0 wins.
- Port 0 back-to-back streaming cannot starve port 1 beyond MAX_WAIT+1 grants.
- Reset mid-read:
  - The in-flight read is discarded with no rvalid; state goes to IDLE and outputs clear.
  - Masters re-issue their requests.
- gnt and rvalid are never asserted for both ports in the same cycle (per signal type).

Test Plan:
- Single write then read: m0 write addr 0x123 data 0xBEEF, then read 0x123 (RD_LAT=1) -> m0_gnt cycle G has ram_en=1, ram_we=1; the read's m0_rvalid arrives 2 cycles after its gnt with rdata=0xBEEF.
- Contention: m0 and m1 both request reads in the same cycle -> m0_gnt first; m1_gnt at the arbitration edge closing m0's last WAIT cycle; m1_rvalid follows with the correct data.
- Starvation: m0 issues continuous writes, m1_req held, MAX_WAIT=4 -> m0 granted 4 times, then m1_gnt; wait_cnt returns to 0; m0 resumes.
- Back-to-back writes: m1 writes 0x000..0x00F -> 16 consecutive grant cycles with ram_en=1; busy stays 0.
- Reset mid-read: RD_LAT=3, rst asserted in second WAIT cycle -> no rvalid ever appears; all outputs 0 the cycle after rst; a subsequent read completes normally.
- Withdrawn request: m1_req pulses one cycle while a read is in WAIT -> no m1_gnt; wait_cnt unchanged.
